// File: rtl/dpll_pkg.sv
// Shared DPLL constants: gear-sequencer state encoding and default loop-gain settings.
package dpll_pkg;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAcq    = 2'd1;
    localparam logic [1:0] StVerify = 2'd2;
    localparam logic [1:0] StLocked = 2'd3;

    localparam logic [3:0] DefKAcq = 4'd2;
    localparam logic [3:0] DefKTrk = 4'd5;
    localparam logic [7:0] DefHAcq = 8'd16;
    localparam logic [7:0] DefHTrk = 8'd32;

endpackage

// File: rtl/dpll_err_meter.sv
// Phase-error activity meter: synchronises errSig and counts error cycles per fixed window.
module dpll_err_meter #(
    parameter int unsigned WIN_LOG2 = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              errSig,
    output logic              winDone,
    output logic [WIN_LOG2:0] errWin,
    output logic [WIN_LOG2:0] errLast
);

    localparam logic [WIN_LOG2:0] ErrMax = {1'b1, {WIN_LOG2{1'b0}}};

    logic                errMeta;
    logic                errSync;
    logic [WIN_LOG2-1:0] winCnt;
    logic [WIN_LOG2:0]   errCnt;

    assign winDone = run && (winCnt == '1);
    // Count including this cycle's sample, so the window total is ready on winDone.
    assign errWin  = (errSync && (errCnt != ErrMax)) ? errCnt + 1'b1 : errCnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            errMeta <= 1'b0;
            errSync <= 1'b0;
            winCnt  <= '0;
            errCnt  <= '0;
            errLast <= '0;
        end else begin
            errMeta <= errSig;
            errSync <= errMeta;
            if (!run) begin
                winCnt <= '0;
                errCnt <= '0;
            end else begin
                winCnt <= winCnt + 1'b1;
                if (winDone) begin
                    errCnt  <= '0;
                    errLast <= errWin;
                end else begin
                    errCnt <= errWin;
                end
            end
        end
    end

endmodule

// File: rtl/dpll_gear_ctrl.sv
// DPLL loop-gain sequencer: switches kMode/H between acquisition and tracking gears.
// Define DPLL_GEAR_STATS_EN to add the saturating lossCount output.
module dpll_gear_ctrl
    import dpll_pkg::*;
#(
    parameter int unsigned WIN_LOG2   = 10,
    parameter int unsigned LOCK_THR   = 64,
    parameter int unsigned UNLOCK_THR = 256,
    parameter int unsigned LOCK_WINS  = 4,
    parameter logic [3:0]  K_ACQ      = DefKAcq,
    parameter logic [3:0]  K_TRK      = DefKTrk,
    parameter logic [7:0]  H_ACQ      = DefHAcq,
    parameter logic [7:0]  H_TRK      = DefHTrk
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              errSig,
    output logic [3:0]        kMode,
    output logic [7:0]        H,
    output logic              cfgUpdate,
    output logic              locked,
    output logic [WIN_LOG2:0] errLast
`ifdef DPLL_GEAR_STATS_EN
    ,
    output logic [7:0]        lossCount
`endif
);

    logic [1:0]        stateQ, stateD;
    logic [3:0]        goodQ, goodD;
    logic              winDone;
    logic [WIN_LOG2:0] errWin;
    logic              winGood;
    logic              winLost;
    logic              goodReached;
    logic              lockedD;

    dpll_err_meter #(
        .WIN_LOG2(WIN_LOG2)
    ) uErrMeter (
        .clk    (clk),
        .reset  (reset),
        .run    (stateQ != StIdle),
        .errSig (errSig),
        .winDone(winDone),
        .errWin (errWin),
        .errLast(errLast)
    );

    assign winGood     = 32'(errWin) < LOCK_THR;
    assign winLost     = 32'(errWin) >= UNLOCK_THR;
    assign goodReached = (32'(goodQ) + 32'd1) >= LOCK_WINS;

    always_comb begin
        stateD = stateQ;
        goodD  = goodQ;
        // Dropping enable wins over any window decision taken on the same cycle.
        if (stateQ != StIdle && !enable) begin
            stateD = StIdle;
            goodD  = '0;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (enable) stateD = StAcq;
                end
                StAcq: begin
                    if (winDone && winGood) begin
                        if (LOCK_WINS == 1) begin
                            stateD = StLocked;
                        end else begin
                            stateD = StVerify;
                            goodD  = 4'd1;
                        end
                    end
                end
                StVerify: begin
                    if (winDone) begin
                        if (!winGood) begin
                            stateD = StAcq;
                            goodD  = '0;
                        end else if (goodReached) begin
                            stateD = StLocked;
                            goodD  = '0;
                        end else begin
                            goodD = goodQ + 4'd1;
                        end
                    end
                end
                StLocked: begin
                    if (winDone && winLost) stateD = StAcq;
                end
                default: begin
                    stateD = StIdle;
                    goodD  = '0;
                end
            endcase
        end
    end

    assign lockedD = (stateD == StLocked);

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ    <= StIdle;
            goodQ     <= '0;
            kMode     <= K_ACQ;
            H         <= H_ACQ;
            cfgUpdate <= 1'b0;
            locked    <= 1'b0;
        end else begin
            stateQ    <= stateD;
            goodQ     <= goodD;
            locked    <= lockedD;
            kMode     <= lockedD ? K_TRK : K_ACQ;
            H         <= lockedD ? H_TRK : H_ACQ;
            cfgUpdate <= lockedD != locked;
        end
    end

`ifdef DPLL_GEAR_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            lossCount <= '0;
        end else if (stateQ == StLocked && stateD == StAcq && lossCount != 8'hff) begin
            lossCount <= lossCount + 8'd1;
        end
    end
`endif

endmodule
